// File: rtl/synth_pwm_pkg.sv
// -----------------------------------------------------------------------------
// synth_pwm_pkg
// Shared definitions for the PWM sample generator and the PWM sample decoder:
// default timing constants, the frame-length and duty-scale derivation
// functions, the decoder state enum and the 16-bit counter type.
// -----------------------------------------------------------------------------
package synth_pwm_pkg;

    // Default system timing shared by generator and decoder.
    localparam int PWM_FCLKM_DEF = 64000000;
    localparam int PWM_FS_DEF    = 44100;
    localparam int PWM_RES_DEF   = 9;

    // Frame/period/high counters are all 16 bits wide.
    typedef logic [15:0] cnt16_t;

    localparam cnt16_t CNT_MAX = 16'hFFFF;

    // Decoder frame-tracking state.
    typedef enum logic [0:0] {
        ST_ACQ   = 1'b0,
        ST_TRACK = 1'b1
    } dec_state_t;

    // Clocks per PWM frame, truncated.
    function automatic int frame_len_f(input int fclk, input int fs);
        return fclk / fs;
    endfunction

    // Fixed-point factor so that (high * scale) >> 16 maps a full frame to 2^res.
    // Rounded to nearest: round(2^(res+16) / frame_len).
    function automatic int scale_f(input int res, input int frame_len);
        longint num;
        num = longint'(1) << (res + 16);
        return int'((num + longint'(frame_len / 2)) / longint'(frame_len));
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// -----------------------------------------------------------------------------
// pwm_in_sync
// Brings the asynchronous PWM pin into the clk domain (2-FF synchroniser),
// optionally debounces it, and detects rising edges with a delay register.
// Optional feature macro: PWM_DEC_GLITCH_FILT_EN (adds a GLITCH_CYC-clock
// persistence filter after the synchroniser).
//
// Ports:
//   i_clk    decoder clock
//   i_rst    synchronous active-high reset
//   i_pwm    asynchronous PWM input
//   o_level  synchronised (and optionally filtered) line level
//   o_rise   one-clock pulse on a low-to-high transition of o_level
// -----------------------------------------------------------------------------
module pwm_in_sync
`ifdef PWM_DEC_GLITCH_FILT_EN
#(
    parameter int GLITCH_CYC = 3
)
`endif
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_dly;
    logic w_level;

    // Two-stage synchroniser plus edge-detect delay register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_pwm;
            r_sync <= r_meta;
            r_dly  <= w_level;
        end
    end

`ifdef PWM_DEC_GLITCH_FILT_EN
    logic       r_filt;
    logic [7:0] r_gcnt;

    // Persistence filter: follow the synced level only after it has differed
    // from the filtered level for GLITCH_CYC consecutive clocks.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_filt <= 1'b0;
            r_gcnt <= 8'd0;
        end else if (r_sync == r_filt) begin
            r_gcnt <= 8'd0;
        end else if (r_gcnt == 8'(GLITCH_CYC - 1)) begin
            r_filt <= r_sync;
            r_gcnt <= 8'd0;
        end else begin
            r_gcnt <= r_gcnt + 8'd1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync;
`endif

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_dly;

endmodule

// File: rtl/pwm_sample_decoder.sv
// -----------------------------------------------------------------------------
// pwm_sample_decoder
// Recovers a RES-bit sample from a PWM waveform by measuring the high time
// and period of every frame. A frame boundary is each rising edge of the
// synchronised input. The duty cycle is scaled with a pipelined 16x16
// multiply; sample_valid follows the boundary clock by exactly two clocks.
// A steady line (0 % / 100 % duty) is detected by a period timeout and
// reported as a full-scale or zero sample while locked.
// Optional feature macro: PWM_DEC_GLITCH_FILT_EN (input glitch filter).
//
// Ports:
//   clk            decoder clock
//   rst            synchronous active-high reset
//   pwm_in         asynchronous PWM input
//   sample         recovered sample, held until the next update
//   sample_valid   one-clock strobe when sample updates
//   high_cycles    high count of the last completed frame
//   period_cycles  period of the last completed frame
//   locked         frame timing stable for LOCK_FRAMES frames
//   frame_err      one-clock strobe on an out-of-range period
// -----------------------------------------------------------------------------
module pwm_sample_decoder
    import synth_pwm_pkg::*;
#(
    parameter int FCLKM       = PWM_FCLKM_DEF,
    parameter int FS          = PWM_FS_DEF,
    parameter int RES         = PWM_RES_DEF,
    parameter int TOL         = 8,
    parameter int LOCK_FRAMES = 4
`ifdef PWM_DEC_GLITCH_FILT_EN
    ,
    parameter int GLITCH_CYC  = 3
`endif
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           pwm_in,
    output logic [RES-1:0] sample,
    output logic           sample_valid,
    output logic [15:0]    high_cycles,
    output logic [15:0]    period_cycles,
    output logic           locked,
    output logic           frame_err
);

    localparam int     FRAME_LEN   = frame_len_f(FCLKM, FS);
    localparam int     SCALE       = scale_f(RES, FRAME_LEN);
    localparam int     LOCK_W      = $clog2(LOCK_FRAMES + 1);
    localparam cnt16_t FRAME_LEN_C = cnt16_t'(FRAME_LEN);
    localparam cnt16_t RANGE_LO_C  = cnt16_t'(FRAME_LEN - TOL);
    localparam cnt16_t RANGE_HI_C  = cnt16_t'(FRAME_LEN + TOL);
    localparam cnt16_t TIMEOUT_C   = cnt16_t'(FRAME_LEN + TOL + 1);
    localparam cnt16_t SCALE_C     = cnt16_t'(SCALE);
    localparam logic [LOCK_W-1:0] LOCK_MAX_C = LOCK_W'(LOCK_FRAMES);
    localparam logic [16:0]       SAMPLE_MAX_Q = 17'((1 << RES) - 1);

    logic              w_level;
    logic              w_rise;
    dec_state_t        r_state;
    cnt16_t            r_period_cnt;
    cnt16_t            r_high_cnt;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_resync;
    logic              r_mul_go;
    logic              r_prod_go;
    logic [31:0]       r_prod;
    logic              w_in_range;
    logic [LOCK_W-1:0] w_lock_next;
    cnt16_t            w_period_inc;
    cnt16_t            w_high_inc;
    logic [16:0]       w_q;
    logic [RES-1:0]    w_sample;

`ifdef PWM_DEC_GLITCH_FILT_EN
    pwm_in_sync #(.GLITCH_CYC(GLITCH_CYC)) u_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_pwm   (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise)
    );
`else
    pwm_in_sync u_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_pwm   (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise)
    );
`endif

    assign w_in_range   = (r_period_cnt >= RANGE_LO_C) && (r_period_cnt <= RANGE_HI_C);
    assign w_lock_next  = (r_lock_cnt == LOCK_MAX_C) ? r_lock_cnt : r_lock_cnt + LOCK_W'(1);
    // Both counters saturate rather than wrap.
    assign w_period_inc = (r_period_cnt == CNT_MAX) ? CNT_MAX : r_period_cnt + 16'd1;
    assign w_high_inc   = (w_level && (r_high_cnt != CNT_MAX)) ? r_high_cnt + 16'd1 : r_high_cnt;

    // Frame tracking FSM: counters, lock tracking, latched measurements.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_ACQ;
            r_period_cnt  <= 16'd0;
            r_high_cnt    <= 16'd0;
            r_lock_cnt    <= '0;
            r_resync      <= 1'b0;
            r_mul_go      <= 1'b0;
            high_cycles   <= 16'd0;
            period_cycles <= 16'd0;
            locked        <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            r_mul_go  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                ST_ACQ: begin
                    r_period_cnt <= 16'd0;
                    r_high_cnt   <= 16'd0;
                    if (w_rise) begin
                        r_state      <= ST_TRACK;
                        r_period_cnt <= 16'd1;
                        r_high_cnt   <= 16'd1;
                    end
                end
                ST_TRACK: begin
                    if (w_rise) begin
                        // Rise wins over a coincident timeout.
                        r_period_cnt <= 16'd1;
                        r_high_cnt   <= 16'd1;
                        if (r_resync) begin
                            // First real edge after a steady line only re-aligns.
                            r_resync <= 1'b0;
                        end else begin
                            high_cycles   <= r_high_cnt;
                            period_cycles <= r_period_cnt;
                            if (w_in_range) begin
                                r_lock_cnt <= w_lock_next;
                                locked     <= (w_lock_next == LOCK_MAX_C);
                                r_mul_go   <= (w_lock_next == LOCK_MAX_C);
                            end else begin
                                frame_err  <= 1'b1;
                                r_lock_cnt <= '0;
                                locked     <= 1'b0;
                            end
                        end
                    end else if (r_period_cnt == TIMEOUT_C) begin
                        // Steady line: treat as a virtual boundary.
                        r_period_cnt <= 16'd1;
                        r_high_cnt   <= 16'd1;
                        r_resync     <= 1'b1;
                        if (locked) begin
                            // Full-frame high count scales (and clamps) to full scale.
                            high_cycles   <= w_level ? FRAME_LEN_C : 16'd0;
                            period_cycles <= FRAME_LEN_C;
                            r_mul_go      <= 1'b1;
                        end
                    end else begin
                        r_period_cnt <= w_period_inc;
                        r_high_cnt   <= w_high_inc;
                    end
                end
                default: begin
                    r_state <= ST_ACQ;
                end
            endcase
        end
    end

    // Round the scaled product to RES bits.
    assign w_q = 17'(({1'b0, r_prod} + 33'h0_0000_8000) >> 16);

    // Clamp: a full-length high time would otherwise round up to 2^RES.
    always_comb begin
        w_sample = w_q[RES-1:0];
        if (w_q > SAMPLE_MAX_Q) begin
            w_sample = '1;
        end else begin
            w_sample = w_q[RES-1:0];
        end
    end

    // Two-stage scaling pipeline: multiply register, then sample register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod       <= 32'd0;
            r_prod_go    <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            r_prod_go    <= r_mul_go;
            sample_valid <= r_prod_go;
            if (r_mul_go) begin
                r_prod <= 32'(high_cycles) * 32'(SCALE_C);
            end
            if (r_prod_go) begin
                sample <= w_sample;
            end
        end
    end

endmodule
